dma_channel_scheduler: RTL and testbench

//  Shares the single DMA engine (read master + write master behind the control slave) among NUM_CH requesters.

---
 rtl/dma_channel_scheduler.sv | 148 ++++++++++++++
 tb/tb_dma_channel_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_scheduler.sv
// Round-robin scheduler sharing one DMA engine among NUM_CH descriptor-holding requesters.
// Latency: request seen at edge N -> grant after N, engine start after N+1; done pulse one edge after engine done.
// Backpressure: one transfer in flight; requesters hold iReq until their oDone, RELEASE waits for iWM_done low.
//
// Ports:
//   iClk, iReset_n        clock, asynchronous active-low reset
//   iReq                  per-channel request level
//   iSrc, iDst, iLen      flattened per-channel descriptors (channel i at [i*W +: W])
//   oGrant, oActive_ch    one-hot owner and its index while oBusy
//   oDone, oErr           one-cycle completion / watchdog-abort pulses to the owner
//   oRM_startaddress, oWM_startaddress, oLength, oStart, iWM_done   DMA engine control
//   oBusy                 high whenever the scheduler is not idle
module dma_channel_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 32,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                          iClk,
    input  logic                          iReset_n,
    input  logic [NUM_CH-1:0]             iReq,
    input  logic [NUM_CH*ADDR_W-1:0]      iSrc,
    input  logic [NUM_CH*ADDR_W-1:0]      iDst,
    input  logic [NUM_CH*LEN_W-1:0]       iLen,
    output logic [NUM_CH-1:0]             oGrant,
    output logic [NUM_CH-1:0]             oDone,
    output logic [NUM_CH-1:0]             oErr,
    output logic [ADDR_W-1:0]             oRM_startaddress,
    output logic [ADDR_W-1:0]             oWM_startaddress,
    output logic [LEN_W-1:0]              oLength,
    output logic                          oStart,
    input  logic                          iWM_done,
    output logic                          oBusy,
    output logic [$clog2(NUM_CH)-1:0]     oActive_ch
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // Watchdog fires on the WAIT edge that completes the TIMEOUT_CYC-th cycle.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LAUNCH  = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]        state;
    logic [CH_W-1:0]   rr_ptr;
    logic [WD_W-1:0]   wd_cnt;
    logic              sel_vld;
    logic [CH_W-1:0]   sel_ch;
    logic [NUM_CH-1:0] sel_onehot;
    logic [CH_W-1:0]   next_ptr;

    // Channel index base+off, wrapped modulo NUM_CH (works for non power-of-two counts).
    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CH) sum = sum - NUM_CH;
        return CH_W'(sum);
    endfunction

    // First requesting channel at or above the pointer, wrapping around.
    always_comb begin
        sel_vld = 1'b0;
        sel_ch  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!sel_vld && iReq[rr_idx(rr_ptr, k)]) begin
                sel_vld = 1'b1;
                sel_ch  = rr_idx(rr_ptr, k);
            end
        end
    end

    assign sel_onehot = NUM_CH'(1) << sel_ch;
    // The served channel drops to lowest priority for the next arbitration.
    assign next_ptr   = (oActive_ch == CH_W'(NUM_CH - 1)) ? '0 : oActive_ch + 1'b1;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state            <= S_IDLE;
            rr_ptr           <= '0;
            wd_cnt           <= '0;
            oGrant           <= '0;
            oDone            <= '0;
            oErr             <= '0;
            oRM_startaddress <= '0;
            oWM_startaddress <= '0;
            oLength          <= '0;
            oStart           <= 1'b0;
            oBusy            <= 1'b0;
            oActive_ch       <= '0;
        end else begin
            oDone <= '0;
            oErr  <= '0;
            case (state)
                S_IDLE: begin
                    if (sel_vld) begin
                        oRM_startaddress <= iSrc[sel_ch*ADDR_W +: ADDR_W];
                        oWM_startaddress <= iDst[sel_ch*ADDR_W +: ADDR_W];
                        oLength          <= iLen[sel_ch*LEN_W +: LEN_W];
                        oGrant           <= sel_onehot;
                        oActive_ch       <= sel_ch;
                        oBusy            <= 1'b1;
                        state            <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // Zero-length transfers complete without touching the engine.
                    if (oLength == '0) begin
                        oDone <= oGrant;
                        state <= S_RELEASE;
                    end else begin
                        oStart <= 1'b1;
                        wd_cnt <= '0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (iWM_done) begin
                        oStart <= 1'b0;
                        oDone  <= oGrant;
                        state  <= S_RELEASE;
                    end else if (TIMEOUT_CYC != 0 && wd_cnt == WD_LAST) begin
                        oStart <= 1'b0;
                        oDone  <= oGrant;
                        oErr   <= oGrant;
                        state  <= S_RELEASE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    oGrant <= '0;
                    // A level-style engine done must drop before the next launch.
                    if (!iWM_done) begin
                        rr_ptr     <= next_ptr;
                        oBusy      <= 1'b0;
                        oActive_ch <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_channel_scheduler.sv
module tb_dma_channel_scheduler;

    logic         iClk;
    logic         iReset_n;
    logic [3:0]   iReq;
    logic [127:0] iSrc;
    logic [127:0] iDst;
    logic [127:0] iLen;
    logic [3:0]   oGrant;
    logic [3:0]   oDone;
    logic [3:0]   oErr;
    logic [31:0]  oRM_startaddress;
    logic [31:0]  oWM_startaddress;
    logic [31:0]  oLength;
    logic         oStart;
    logic         iWM_done;
    logic         oBusy;
    logic [1:0]   oActive_ch;

    int errors = 0;
    int checks = 0;

    dma_channel_scheduler #(
        .NUM_CH(4), .ADDR_W(32), .LEN_W(32), .TIMEOUT_CYC(16)
    ) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iReq(iReq), .iSrc(iSrc), .iDst(iDst), .iLen(iLen),
        .oGrant(oGrant), .oDone(oDone), .oErr(oErr),
        .oRM_startaddress(oRM_startaddress), .oWM_startaddress(oWM_startaddress),
        .oLength(oLength), .oStart(oStart), .iWM_done(iWM_done), .oBusy(oBusy),
        .oActive_ch(oActive_ch)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iReset_n = 1'b0; iReq = '0; iWM_done = 1'b0;
        iSrc = '0; iDst = '0; iLen = '0;
        tick(); tick();
        checks++;
        if ({oGrant, oDone, oErr, oStart, oBusy, oActive_ch} !== 15'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got grant=%b done=%b err=%b start=%b busy=%b ch=%0d want all 0",
                     oGrant, oDone, oErr, oStart, oBusy, oActive_ch);
        end
        checks++;
        if ({oRM_startaddress, oWM_startaddress, oLength} !== 96'd0) begin
            errors++;
            $display("FAIL reset_desc: got rm=%h wm=%h len=%h want 0", oRM_startaddress, oWM_startaddress, oLength);
        end
        iReset_n = 1'b1;
        tick();
        checks++;
        if (oBusy !== 1'b0 || oGrant !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle_noreq: got busy=%b grant=%b want 0 0000", oBusy, oGrant);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        for (int i = 0; i < 4; i++) begin
            iSrc[i*32 +: 32] = 32'h1000_0000 + 32'(i) * 32'h100;
            iDst[i*32 +: 32] = 32'h2000_0000 + 32'(i) * 32'h100;
            iLen[i*32 +: 32] = 32'd16 * 32'(i + 1);
        end
        iReq = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_oh = 4'b0001 << (n % 4);
            tick();
            checks++;
            if (oGrant !== exp_oh || oActive_ch !== 2'(n % 4) || oBusy !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got grant=%b ch=%0d busy=%b want %b %0d 1",
                         n, oGrant, oActive_ch, oBusy, exp_oh, n % 4);
            end
            tick();
            checks++;
            if (oStart !== 1'b1 || oRM_startaddress !== 32'h1000_0000 + 32'(n % 4) * 32'h100 ||
                oLength !== 32'd16 * 32'((n % 4) + 1)) begin
                errors++;
                $display("FAIL rr_launch[%0d]: got start=%b rm=%h len=%0d", n, oStart, oRM_startaddress, oLength);
            end
            iWM_done = 1'b1;
            tick();
            checks++;
            if (oDone !== exp_oh || oStart !== 1'b0 || oErr !== 4'b0000) begin
                errors++;
                $display("FAIL rr_done[%0d]: got done=%b start=%b err=%b want %b 0 0000",
                         n, oDone, oStart, oErr, exp_oh);
            end
            iWM_done = 1'b0;
            tick();
            checks++;
            if (oDone !== 4'b0000 || oGrant !== 4'b0000 || oBusy !== 1'b0) begin
                errors++;
                $display("FAIL rr_release[%0d]: got done=%b grant=%b busy=%b want 0000 0000 0",
                         n, oDone, oGrant, oBusy);
            end
        end
        iReq = 4'b0000;
    endtask

    // Pointer is at 1 here; reset must restore channel 0 priority.
    task automatic test_reset_mid_wait();
        iReq = 4'b1111;
        tick(); tick();
        checks++;
        if (oStart !== 1'b1 || oGrant !== 4'b0010) begin
            errors++;
            $display("FAIL rst_wait_setup: got start=%b grant=%b want 1 0010", oStart, oGrant);
        end
        iReset_n = 1'b0;
        #1;
        checks++;
        if (oStart !== 1'b0 || oGrant !== 4'b0000 || oBusy !== 1'b0 || oDone !== 4'b0000) begin
            errors++;
            $display("FAIL rst_wait_async: got start=%b grant=%b busy=%b done=%b want 0", oStart, oGrant, oBusy, oDone);
        end
        tick();
        iReset_n = 1'b1;
        tick();
        checks++;
        if (oGrant !== 4'b0001 || oActive_ch !== 2'd0) begin
            errors++;
            $display("FAIL rst_wait_regrant: got grant=%b ch=%0d want 0001 0", oGrant, oActive_ch);
        end
        tick();
        iWM_done = 1'b1; tick();
        iWM_done = 1'b0; iReq = 4'b0000; tick();
    endtask

    task automatic test_single_req();
        int start_seen;
        iSrc[32 +: 32] = 32'h1000; iDst[32 +: 32] = 32'h2000; iLen[32 +: 32] = 32'd64;
        iReq = 4'b0010;
        tick();
        checks++;
        if (oGrant !== 4'b0010 || oStart !== 1'b0 || oBusy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got grant=%b start=%b busy=%b want 0010 0 1", oGrant, oStart, oBusy);
        end
        // Descriptor and foreign-request changes after the grant must have no effect.
        iSrc[32 +: 32] = 32'hDEAD; iLen[32 +: 32] = 32'd0;
        tick();
        checks++;
        if (oStart !== 1'b1 || oRM_startaddress !== 32'h1000 || oWM_startaddress !== 32'h2000 || oLength !== 32'd64) begin
            errors++;
            $display("FAIL single_launch: got start=%b rm=%h wm=%h len=%0d want 1 1000 2000 64",
                     oStart, oRM_startaddress, oWM_startaddress, oLength);
        end
        iReq = 4'b1000;
        start_seen = 0;
        for (int c = 0; c < 9; c++) begin
            tick();
            if (oStart === 1'b1 && oGrant === 4'b0010 && oRM_startaddress === 32'h1000) start_seen++;
        end
        checks++;
        if (start_seen != 9) begin
            errors++;
            $display("FAIL single_wait_hold: got %0d stable cycles want 9", start_seen);
        end
        iWM_done = 1'b1;
        tick();
        checks++;
        if (oDone !== 4'b0010 || oStart !== 1'b0 || oErr !== 4'b0000) begin
            errors++;
            $display("FAIL single_done: got done=%b start=%b err=%b want 0010 0 0000", oDone, oStart, oErr);
        end
        iWM_done = 1'b0; iReq = 4'b0000;
        tick();
        checks++;
        if (oBusy !== 1'b0 || oDone !== 4'b0000 || oGrant !== 4'b0000) begin
            errors++;
            $display("FAIL single_release: got busy=%b done=%b grant=%b want 0", oBusy, oDone, oGrant);
        end
        iSrc[32 +: 32] = 32'h1000; iLen[32 +: 32] = 32'd64;
    endtask

    task automatic test_zero_length();
        int start_hits;
        start_hits = 0;
        iLen[64 +: 32] = 32'd0;
        iReq = 4'b0100;
        tick();
        if (oStart === 1'b1) start_hits++;
        checks++;
        if (oGrant !== 4'b0100) begin
            errors++;
            $display("FAIL zero_grant: got %b want 0100", oGrant);
        end
        iReq = 4'b0000;
        tick();
        if (oStart === 1'b1) start_hits++;
        checks++;
        if (oDone !== 4'b0100 || oErr !== 4'b0000) begin
            errors++;
            $display("FAIL zero_done: got done=%b err=%b want 0100 0000", oDone, oErr);
        end
        tick();
        if (oStart === 1'b1) start_hits++;
        checks++;
        if (start_hits != 0 || oBusy !== 1'b0 || oDone !== 4'b0000) begin
            errors++;
            $display("FAIL zero_nostart: got start_hits=%0d busy=%b done=%b want 0 0 0000", start_hits, oBusy, oDone);
        end
    endtask

    task automatic test_level_done();
        int done_pulses;
        int early_grant;
        iLen[96 +: 32] = 32'd8; iLen[0 +: 32] = 32'd4;
        iReq = 4'b1000;
        tick(); tick();
        iReq = 4'b1001;
        iWM_done = 1'b1;
        done_pulses = 0; early_grant = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (oDone === 4'b1000) done_pulses++;
            else if (oDone !== 4'b0000) done_pulses += 10;
            if (c > 0 && (oGrant !== 4'b0000 || oBusy !== 1'b1)) early_grant++;
        end
        checks++;
        if (done_pulses != 1) begin
            errors++;
            $display("FAIL level_single_pulse: got %0d want 1", done_pulses);
        end
        checks++;
        if (early_grant != 0) begin
            errors++;
            $display("FAIL level_hold_release: got %0d bad cycles want 0", early_grant);
        end
        iWM_done = 1'b0;
        tick();
        checks++;
        if (oBusy !== 1'b0 || oGrant !== 4'b0000) begin
            errors++;
            $display("FAIL level_exit: got busy=%b grant=%b want 0 0000", oBusy, oGrant);
        end
        tick();
        checks++;
        if (oGrant !== 4'b0001) begin
            errors++;
            $display("FAIL level_next_grant: got %b want 0001", oGrant);
        end
        tick();
        iWM_done = 1'b1; tick();
        iWM_done = 1'b0; iReq = 4'b0000; tick();
    endtask

    // TIMEOUT_CYC is 16: start stays up for 16 WAIT cycles then aborts.
    task automatic test_watchdog();
        int start_cycles;
        int early_err;
        iReq = 4'b0010;
        tick(); tick();
        start_cycles = 0; early_err = 0;
        for (int c = 0; c < 15; c++) begin
            if (oStart === 1'b1) start_cycles++;
            if (oErr !== 4'b0000 || oDone !== 4'b0000) early_err++;
            tick();
        end
        if (oStart === 1'b1) start_cycles++;
        checks++;
        if (start_cycles != 16 || early_err != 0) begin
            errors++;
            $display("FAIL wd_hold: got start_cycles=%0d early=%0d want 16 0", start_cycles, early_err);
        end
        tick();
        checks++;
        if (oStart !== 1'b0 || oDone !== 4'b0010 || oErr !== 4'b0010) begin
            errors++;
            $display("FAIL wd_abort: got start=%b done=%b err=%b want 0 0010 0010", oStart, oDone, oErr);
        end
        iReq = 4'b0000;
        tick();
        checks++;
        if (oErr !== 4'b0000 || oDone !== 4'b0000 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL wd_release: got err=%b done=%b busy=%b want 0000 0000 0", oErr, oDone, oBusy);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_reset_mid_wait();
        test_single_req();
        test_zero_length();
        test_level_done();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
